// File: rtl/mul_div_if.sv
// Handshake and data bundle between the execute-stage control and the multiply/divide unit.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; WIDTH cycles per operation.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mul_div_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned W2    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [W2-1:0]    ONE2 = W2'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_w_hi;
  logic [WIDTH-1:0] r_w_lo;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_a_orig;
  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_last;
  logic             w_signed;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  // Start is honoured outside RUN for non-reserved opcodes only.
  assign w_accept = bus.start & ~bus.op[2] & (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(1));
  assign w_signed = ~bus.op[0];
  assign w_a_abs  = (w_signed && bus.a[WIDTH-1]) ? (~bus.a + ONE) : bus.a;
  assign w_b_abs  = (w_signed && bus.b[WIDTH-1]) ? (~bus.b + ONE) : bus.b;

  // Single datapath step: {hi,lo} is the product/multiplier pair or remainder/quotient pair.
  always_comb begin
    w_mul_sum   = {1'b0, r_w_hi} + (r_w_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_w_hi, r_w_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    w_div_diff  = w_div_shift - {1'b0, r_opb};
    if (r_is_div) begin
      w_step_hi = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_step_lo = {r_w_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], r_w_lo[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step's magnitudes.
  always_comb begin
    w_prod     = {w_step_hi, w_step_lo};
    w_prod_fix = r_neg_lo ? (~w_prod + ONE2) : w_prod;
    w_quo_fix  = r_neg_lo ? (~w_step_lo + ONE) : w_step_lo;
    w_rem_fix  = r_neg_hi ? (~w_step_hi + ONE) : w_step_hi;
    if (!r_is_div) begin
      w_res_hi = w_prod_fix[W2-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end else if (r_dbz) begin
      w_res_hi = r_a_orig;
      w_res_lo = {WIDTH{1'b1}};
    end else begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quo_fix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last)   w_state_next = S_DONE;
      S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status flags are pure state decodes, so they change only on clock edges.
  always_comb begin
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.div_by_zero = 1'b0;
    case (r_state)
      S_RUN:  bus.busy = 1'b1;
      S_DONE: begin
        bus.done        = 1'b1;
        bus.div_by_zero = r_dbz;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_w_hi   <= '0;
      r_w_lo   <= '0;
      r_opb    <= '0;
      r_a_orig <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CNT_W'(WIDTH);
      r_w_hi   <= '0;
      r_w_lo   <= w_a_abs;
      r_opb    <= w_b_abs;
      r_a_orig <= bus.a;
      r_is_div <= bus.op[1];
      r_neg_lo <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_neg_hi <= w_signed & bus.op[1] & bus.a[WIDTH-1];
      r_dbz    <= bus.op[1] & (bus.b == '0);
    end else if (r_state == S_RUN) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_w_hi   <= w_step_hi;
      r_w_lo   <= w_step_lo;
    end
  end

  // HI/LO: final result, or MTHI/MTLO when idle and no start is being accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if ((r_state != S_RUN) && !w_accept) begin
      if (bus.we_hi) r_hi <= bus.wd;
      if (bus.we_lo) r_lo <= bus.wd;
    end
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mul_div_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; entered and left 1ns after a rising edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; reports edges elapsed and cycles seen busy.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
  endtask

  task automatic test_multu_max();
    int cyc, bcnt;
    start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL multu_latency got=%0d exp=32", cyc); end
    checks++; if (bcnt !== 32) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=32", bcnt); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL multu_dbz got=%b exp=0", bus.div_by_zero); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    start_op(3'b000, 32'hFFFF_FFFD, 32'd5);
    wait_done(cyc, bcnt);
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg_lo got=%h exp=fffffff1", bus.lo); end
    start_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL b2b_no_idle got busy,done=%b exp=10", {bus.busy, bus.done}); end
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL div_latency got=%0d exp=32", cyc); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got=%h exp=fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got=%h exp=ffffffff", bus.hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_by_zero();
    int cyc, bcnt;
    start_op(3'b011, 32'd100, 32'd0);
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_early got=%b exp=0", bus.div_by_zero); end
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL dbz_latency got=%0d exp=32", cyc); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b exp=1", bus.div_by_zero); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got=%h exp=ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h0000_0064) begin errors++; $display("FAIL dbz_hi got=%h exp=00000064", bus.hi); end
    @(posedge clk); #1;
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_after got=%b exp=0", bus.div_by_zero); end
  endtask

  task automatic test_div_overflow();
    int cyc, bcnt;
    start_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bcnt);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got=%h exp=80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got=%h exp=00000000", bus.hi); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz got=%b exp=0", bus.div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_mtlo();
    int cyc, bcnt;
    bus.we_hi = 1'b1;
    bus.wd    = 32'h1234_5678;
    @(posedge clk); #1;
    bus.we_hi = 1'b0;
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got=%h exp=12345678", bus.hi); end
    start_op(3'b001, 32'd6, 32'd7);
    bus.we_lo = 1'b1;
    bus.wd    = 32'h0000_DEAD;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL run_hold_hi got=%h exp=12345678", bus.hi); end
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL run_ignore_mtlo got=%h exp=80000000", bus.lo); end
    bus.we_lo = 1'b0;
    wait_done(cyc, bcnt);
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL mul67_hi got=%h exp=00000000", bus.hi); end
    checks++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL mul67_lo got=%h exp=0000002a", bus.lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int cyc, bcnt;
    start_op(3'b011, 32'd1000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL midrst_hi got=%h exp=00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL midrst_lo got=%h exp=00000000", bus.lo); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    start_op(3'b001, 32'd2, 32'd3);
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL post_rst_latency got=%0d exp=32", cyc); end
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL post_rst_lo got=%h exp=00000006", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL post_rst_hi got=%h exp=00000000", bus.hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved_op();
    start_op(3'b100, 32'd9, 32'd9);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reserved_busy got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reserved_done got=%b exp=0", bus.done); end
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL reserved_lo got=%h exp=00000006", bus.lo); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    bus.wd    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_multu_max();
    test_back_to_back();
    test_div_by_zero();
    test_div_overflow();
    test_mthi_mtlo();
    test_reset_mid_op();
    test_reserved_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative radix-2 multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sits beside the single-cycle ALU in the execute stage and extends it with MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand width and HI/LO width; must be ≥ 4 and even.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled on rising edge
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx reserved
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
we_hi  input  1  MTHI write enable
we_lo  input  1  MTLO write enable
wd  input  WIDTH  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO hold the new result
div_by_zero  output  1  qualifies done; the completed op was a division by zero
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, internal counter and operand registers=0. A reset mid-operation abandons the operation and leaves no partial result.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 and op[2]=0: on the edge, latch |a| and |b|. Signed ops (op[0]=0) take the two's-complement magnitude as a WIDTH-bit unsigned value. On the same edge, record result signs, record div_by_zero_pending = (op[1] & b==0), load counter=WIDTH, and go to RUN.
- start with op[2]=1 is ignored; state is unchanged and done deasserts as normal.
- RUN: one shift-add (mult) or restoring shift-subtract (div) step per edge; counter decrements per step.
  - busy=1 throughout RUN.
  - start, we_hi and we_lo are ignored while in RUN.
- Last step (counter==1): the same edge writes hi/lo with sign-corrected results and enters DONE.
- Latency: start sampled at edge k, result visible after edge k+WIDTH; done=1 for exactly the cycle after that edge.
- DONE: done=1, busy=0, div_by_zero=pending flag. Next edge goes to IDLE, or to RUN if a valid start is present (back-to-back operations allowed). done and div_by_zero are 0 in IDLE and RUN.
- Multiply: {hi,lo} = 2·WIDTH-bit product. For signed ops the 2·WIDTH-bit magnitude is negated when sign(a)≠sign(b).
- Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - -2^(WIDTH-1) / -1 gives lo=-2^(WIDTH-1) (0x80000000), hi=0; no flag.
- Divide by zero: full WIDTH-cycle latency is still taken. Result is lo = all ones, hi = original a (unmodified). div_by_zero=1 together with done.
- MTHI/MTLO: in IDLE or DONE, we_hi/we_lo write wd into hi/lo on the edge; both may be written on the same edge.
- start and we_* asserted together in IDLE/DONE: start wins and the writes are dropped.
- hi/lo change only on reset, on the last RUN step, or on an accepted we_* write. They hold their value during RUN, so reads stall only on busy.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 32 cycles; done pulses 1 cycle after edge 32; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD), b=5, then back-to-back DIV a=-7, b=2 started in the DONE cycle -> first hi=0xFFFFFFFF, lo=0xFFFFFFF1; second lo=0xFFFFFFFD, hi=0xFFFFFFFF; no IDLE cycle between the two operations.
- DIVU a=100, b=0 -> after 32 steps lo=0xFFFFFFFF, hi=0x00000064; div_by_zero=1 only while done=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- MTHI wd=0x12345678 in IDLE, then start MULTU 6×7 with we_lo=1 and wd=0xDEAD during RUN -> hi=0x12345678 until completion; the we_lo write is ignored; final hi=0, lo=42.
- Assert reset at step 10 of a DIVU -> busy, done, hi and lo go to 0 immediately; a subsequent MULTU 2×3 completes normally with lo=6. start with op=100 in IDLE -> busy stays 0.
